// File: rtl/pic_ack_if.sv
// Handshake and status signals between pic_ack_master and its PIC/consumer side.
// The 8-bit PIC data bus is bidirectional and stays a plain port on the master.
interface pic_ack_if;
   logic        int_in;
   logic        intackN;
   logic [1:0]  select;
   logic        readwrite;
   logic        mask_wr;
   logic [7:0]  mask_in;
   logic        vec_valid;
   logic        vec_ready;
   logic [7:0]  vector;
   logic        busy;
   logic [15:0] svc_count;
   logic        spurious;

   modport master (
      input  int_in, mask_wr, mask_in, vec_ready,
      output intackN, select, readwrite, vec_valid, vector, busy, svc_count, spurious
   );

   modport slave (
      output int_in, mask_wr, mask_in, vec_ready,
      input  intackN, select, readwrite, vec_valid, vector, busy, svc_count, spurious
   );
endinterface

// File: rtl/pic_ack_master.sv
// Interrupt acknowledge master for a PIC: acknowledges, reads the vector, hands it
// to a consumer over valid/ready, then writes EOI. Also services mask-register writes.
module pic_ack_master #(
   parameter int unsigned ACK_CYCLES = 2,
   parameter logic [7:0]  EOI_CMD    = 8'h20
) (
   input  logic       clk,
   input  logic       resetN,
   pic_ack_if.master  bus,
   inout  wire  [7:0] data
);

   typedef enum logic [2:0] {
      IDLE, MASK, ACK, READ, CAPTURE, PRESENT, EOI
   } state_t;

   localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  ack_cnt, ack_cnt_nxt;
   logic [7:0]  mask_q, mask_nxt;
   logic [7:0]  vector_q;
   logic [15:0] svc_q;
   logic        spur_q, spur_nxt;

   logic        intack_n;
   logic [1:0]  sel;
   logic        rw;
   logic        drive;
   logic [7:0]  dout;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state    <= IDLE;
         ack_cnt  <= 4'd0;
         mask_q   <= 8'h00;
         vector_q <= 8'h00;
         svc_q    <= 16'h0000;
         spur_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         ack_cnt <= ack_cnt_nxt;
         mask_q  <= mask_nxt;
         spur_q  <= spur_nxt;
         // Bus had a full READ cycle to settle before this sample.
         if (state == CAPTURE) vector_q <= data;
         if (state == EOI)     svc_q    <= svc_q + 16'd1;
      end
   end

   always_comb begin
      state_nxt   = state;
      ack_cnt_nxt = ack_cnt;
      mask_nxt    = mask_q;
      spur_nxt    = 1'b0;
      case (state)
         IDLE: begin
            ack_cnt_nxt = 4'd0;
            // A mask write wins; int_in is looked at again once back in IDLE.
            if (bus.mask_wr) begin
               mask_nxt  = bus.mask_in;
               state_nxt = MASK;
            end else if (bus.int_in) begin
               state_nxt = ACK;
            end
         end
         MASK:    state_nxt = IDLE;
         ACK: begin
            if (!bus.int_in) begin
               state_nxt = IDLE;
               spur_nxt  = 1'b1;
            end else if (ack_cnt == ACK_LAST) begin
               state_nxt = READ;
            end else begin
               ack_cnt_nxt = ack_cnt + 4'd1;
            end
         end
         READ:    state_nxt = CAPTURE;
         CAPTURE: state_nxt = PRESENT;
         PRESENT: if (bus.vec_ready) state_nxt = EOI;
         EOI:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs decode straight from state so reset forces them in the same edge.
   always_comb begin
      intack_n = 1'b1;
      sel      = 2'b00;
      rw       = 1'b1;
      drive    = 1'b0;
      dout     = EOI_CMD;
      case (state)
         MASK: begin
            sel   = 2'b01;
            rw    = 1'b0;
            drive = 1'b1;
            dout  = mask_q;
         end
         ACK:     intack_n = 1'b0;
         EOI: begin
            sel   = 2'b10;
            rw    = 1'b0;
            drive = 1'b1;
            dout  = EOI_CMD;
         end
         default: ;
      endcase
   end

   assign data          = drive ? dout : 8'bzzzz_zzzz;
   assign bus.intackN   = intack_n;
   assign bus.select    = sel;
   assign bus.readwrite = rw;
   assign bus.vec_valid = (state == PRESENT);
   assign bus.vector    = vector_q;
   assign bus.busy      = (state != IDLE);
   assign bus.svc_count = svc_q;
   assign bus.spurious  = spur_q;

endmodule

// File: tb/tb_pic_ack_master.sv
// Randomized plus directed bench for pic_ack_master against a service-timeline model.
module tb_pic_ack_master;
   localparam int A = 2;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] pic_val;
   wire  [7:0] data;

   always #5 clk = ~clk;

   pic_ack_if bus();

   // PIC model: drives its register onto the bus whenever the master reads.
   assign data = bus.readwrite ? pic_val : 8'bzzzz_zzzz;

   pic_ack_master #(.ACK_CYCLES(A), .EOI_CMD(8'h20)) dut (
      .clk(clk), .resetN(resetN), .bus(bus), .data(data)
   );

   // Model: kind 0 idle, 1 mask write, 2 service; age counts clocks since ACK start.
   int          m_kind = 0;
   int          m_age  = 0;
   bit          m_done = 1'b0;
   bit          m_spur = 1'b0;
   logic [7:0]  m_mask = 8'h00;
   logic [7:0]  m_vec  = 8'h00;
   logic [15:0] m_svc  = 16'h0000;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      m_spur = 1'b0;
      if (!resetN) begin
         m_kind = 0; m_age = 0; m_done = 1'b0;
         m_mask = 8'h00; m_vec = 8'h00; m_svc = 16'h0000;
         return;
      end
      case (m_kind)
         0: begin
            if (bus.mask_wr) begin
               m_kind = 1; m_mask = bus.mask_in;
            end else if (bus.int_in) begin
               m_kind = 2; m_age = 0; m_done = 1'b0;
            end
         end
         1: m_kind = 0;
         default: begin
            if (m_done) begin
               m_svc = m_svc + 16'd1; m_kind = 0;
            end else if (m_age < A) begin
               if (!bus.int_in) begin m_kind = 0; m_spur = 1'b1; end
               else m_age++;
            end else if (m_age == A + 2) begin
               if (bus.vec_ready) m_done = 1'b1;
            end else begin
               if (m_age == A + 1) m_vec = pic_val;
               m_age++;
            end
         end
      endcase
   endtask

   task automatic check_outputs();
      bit ack, eoi, msk;
      ack = (m_kind == 2) && (m_age < A);
      eoi = (m_kind == 2) && m_done;
      msk = (m_kind == 1);
      chk("intackN",   32'(bus.intackN),   32'(!ack));
      chk("select",    32'(bus.select),    msk ? 32'd1 : (eoi ? 32'd2 : 32'd0));
      chk("readwrite", 32'(bus.readwrite), 32'(!(msk || eoi)));
      chk("busy",      32'(bus.busy),      32'(m_kind != 0));
      chk("vec_valid", 32'(bus.vec_valid), 32'((m_kind == 2) && (m_age == A + 2) && !m_done));
      chk("vector",    32'(bus.vector),    32'(m_vec));
      chk("svc_count", 32'(bus.svc_count), 32'(m_svc));
      chk("spurious",  32'(bus.spurious),  32'(m_spur));
      if (msk || eoi) chk("data_write", 32'(data), msk ? 32'(m_mask) : 32'h20);
      else            chk("data_read",  32'(data), 32'(pic_val));
   endtask

   task automatic cyc(input logic r, input logic ii, input logic mw,
                      input logic [7:0] mi, input logic vr, input logic [7:0] pv);
      resetN        = r;
      bus.int_in    = ii;
      bus.mask_wr   = mw;
      bus.mask_in   = mi;
      bus.vec_ready = vr;
      pic_val       = pv;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   logic ii_r;

   initial begin
      // Reset
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 8'h11);
      // Basic service with vec_ready held high, vector 4A
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h4A);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h4A);
      // Spurious: int_in drops on the first ACK clock
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33);
      // Mask write colliding with int_in rise, then full service
      cyc(1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 8'h5C);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 8'h5C);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h5C);
      // Long stall in PRESENT, bus value wandering after capture
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'(8'h60 + i));
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
      // svc_count wrap from FFFF
      force dut.svc_q = 16'hFFFF;
      #1;
      release dut.svc_q;
      m_svc = 16'hFFFF;
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C);
      chk("svc_wrapped", 32'(bus.svc_count), 32'h0);
      // Reset for one clock while presenting
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h99);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h99);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99);
      // Random traffic
      ii_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 4) == 0) ii_r = ~ii_r;
         cyc(($urandom_range(0, 299) != 0), ii_r, ($urandom_range(0, 11) == 0),
             8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pic_ack_master.md
PIC_ACK_MASTER -- requirements
Module: pic_ack_master

Interface
REQ-001 SHALL have parameter ACK_CYCLES, default 2: number of clocks intackN is held low, legal range 1..15.
REQ-002 SHALL have parameter EOI_CMD, default 8'h20: byte written to the command register to end an interrupt.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetN, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port int_in, input, 1: interrupt-pending line from the PIC int_out.
REQ-006 SHALL have port intackN, output, 1: active-low interrupt acknowledge to the PIC.
REQ-007 SHALL have port data, inout, 8: PIC register data bus; driven only during a write cycle, high-Z otherwise.
REQ-008 SHALL have port select, output, 2: PIC register select (2'b00 vector, 2'b01 mask, 2'b10 command).
REQ-009 SHALL have port readwrite, output, 1: 1 = read, 0 = write.
REQ-010 SHALL have port mask_wr, input, 1: one-clock request to write mask_in to the PIC mask register.
REQ-011 SHALL have port mask_in, input, 8: mask value.
REQ-012 SHALL have port vec_valid, output, 1: vector available to the consumer.
REQ-013 SHALL have port vec_ready, input, 1: consumer accepts the vector.
REQ-014 SHALL have port vector, output, 8: captured interrupt vector.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port svc_count, output, 16: number of completed EOI cycles.
REQ-017 SHALL have port spurious, output, 1: one-clock pulse when an acknowledge is aborted.

Function
REQ-018 SHALL implement states IDLE, MASK, ACK, READ, CAPTURE, PRESENT and EOI.
REQ-019 IDLE: with mask_wr=1, SHALL latch mask_in and go to MASK; if mask_wr=1 and int_in=1 in the same clock, mask_wr wins and int_in is re-evaluated on the return to IDLE.
REQ-020 IDLE: with int_in=1 and mask_wr=0, SHALL go to ACK.
REQ-021 MASK: SHALL drive select=2'b01, readwrite=0 and data=latched mask for exactly 1 clock, then return to IDLE.
REQ-022 ACK: SHALL hold intackN=0 for exactly ACK_CYCLES clocks, counted by a 4-bit counter, then go to READ.
REQ-023 ACK: if int_in=0 on any ACK clock, SHALL release intackN the next clock, pulse spurious for 1 clock and return to IDLE without a register access.
REQ-024 READ: SHALL drive select=2'b00 and readwrite=1 for 1 clock (bus settle), then go to CAPTURE.
REQ-025 CAPTURE: SHALL keep select=2'b00 and readwrite=1, register data into vector, and go to PRESENT; vec_valid rises the following clock.
REQ-026 PRESENT: SHALL hold vec_valid=1 and vector stable until a clock with vec_ready=1; that clock is the transfer.
REQ-027 On the transfer SHALL deassert vec_valid the next clock and go to EOI; a vec_ready asserted while vec_valid=0 SHALL be ignored.
REQ-028 EOI: SHALL drive select=2'b10, readwrite=0 and data=EOI_CMD for exactly 1 clock, increment svc_count (wraps 16'hFFFF -> 16'h0000), then return to IDLE.
REQ-029 Outside MASK and EOI SHALL keep readwrite=1 and data high-Z; outside READ and CAPTURE select SHALL be 2'b00 unless in MASK or EOI.
REQ-030 A mask_wr arriving outside IDLE SHALL be dropped, not queued.
REQ-031 Minimum service latency, int_in rise to vec_valid=1: ACK_CYCLES+3 clocks.
REQ-032 int_in still high on return to IDLE from EOI SHALL start a new ACK on the next clock with no idle gap.

Reset
REQ-033 While resetN=0 at a clock edge SHALL enter IDLE with intackN=1, select=2'b00, readwrite=1, data high-Z, vec_valid=0, vector=8'h00, busy=0, svc_count=0, spurious=0 and counters cleared.
REQ-034 Reset asserted in any state, including mid-ACK or mid-PRESENT, SHALL abort without an EOI write and without incrementing svc_count.

Verification
REQ-035 int_in=1, PIC returns 8'h4A, vec_ready held 1 -> intackN low 2 clocks, vec_valid high at clock 5 with vector=8'h4A, EOI write of 8'h20 on select=2'b10, svc_count=1.
REQ-036 int_in drops on the 1st ACK clock -> spurious pulses once, no read or write on select, svc_count unchanged, busy=0 two clocks later.
REQ-037 mask_wr=1 with mask_in=8'hF0 in the same clock as an int_in rise -> one write of 8'hF0 on select=2'b01, then the ACK sequence starts.
REQ-038 vec_ready held 0 for 10 clocks in PRESENT -> vec_valid and vector stable for all 10 clocks, no EOI until the clock after vec_ready=1.
REQ-039 svc_count preloaded to 16'hFFFF by 65535 services (or forced), one more service -> svc_count=16'h0000.
REQ-040 resetN=0 for one clock during PRESENT -> next clock all outputs at reset values, data high-Z, no EOI write observed.
